board_ram_arbiter: RTL and testbench
====================================

Name: board_ram_arbiter

Overview:
- Shares the single-port 64-entry chess board-state RAM between two requesters: the VGA square renderer (read-only, latency-critical) and the NIOS II Avalon-MM slave (read/write).
- Sits between the SoC's board-state Avalon slave, the VGA pixel pipeline and the on-chip RAM (M9K, synchronous read, 1-cycle latency).
- VGA has priority during active video. The CPU has priority during blanking. A starvation counter guarantees CPU progress.

Parameters:
ADDR_W, 6, board RAM address width (64 squares)
DATA_W, 4, piece code width (colour bit + 3-bit piece type)
STARVE_MAX, 15, consecutive cycles a pending CPU request may be denied before it is force-granted

Ports:
Clk  in  1  system clock (50 MHz domain)
Reset_h  in  1  asynchronous active-high reset
vga_blank  in  1  1 = horizontal/vertical blanking interval
vga_req  in  1  VGA read request; level, held with vga_addr until vga_gnt
vga_addr  in  ADDR_W  square index requested by renderer
vga_gnt  out  1  VGA request accepted this cycle
vga_valid  out  1  vga_rdata valid (one cycle after vga_gnt)
vga_rdata  out  DATA_W  piece code for granted VGA read
avl_read  in  1  Avalon read
avl_write  in  1  Avalon write
avl_addr  in  ADDR_W  Avalon word address
avl_writedata  in  DATA_W  Avalon write data
avl_readdata  out  DATA_W  Avalon read data
avl_waitrequest  out  1  Avalon waitrequest
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data (valid one cycle after address)

Behaviour:
- One RAM access per cycle. The grant is decided combinationally from the current requests, cpu_state and starve_cnt.
- cpu_pending = (avl_read | avl_write) & cpu_state==IDLE.
- CPU grant when cpu_pending & (~vga_req | vga_blank | starve_cnt==STARVE_MAX). Otherwise VGA is granted if vga_req.
- avl_read and avl_write both high: treated as a write. The read is ignored.
- CPU FSM states:
  - IDLE -> RD_DATA on a granted read.
  - IDLE -> IDLE on a granted write. The write completes in the grant cycle: ram_we=1 and avl_waitrequest=0 in that same cycle.
  - RD_DATA -> IDLE unconditionally. In that cycle avl_waitrequest=0 and avl_readdata=ram_rdata.
  - The CPU is not grant-eligible while in RD_DATA. VGA may use the RAM in that cycle.
- avl_waitrequest is 1 in every cycle other than a write-grant cycle or the RD_DATA cycle, including cycles with no request.
- VGA read path:
  - Grant in cycle N: ram_addr=vga_addr, vga_gnt=1.
  - Cycle N+1: registered vga_valid=1, vga_rdata=ram_rdata.
  - Back-to-back VGA grants give vga_valid on consecutive cycles.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments each cycle cpu_pending is high and not granted.
  - Clears on a CPU grant or when cpu_pending=0.
  - Saturates at STARVE_MAX.
- Idle RAM: ram_we=0, ram_addr holds its last value (registered mux select), ram_wdata don't-care.
- Reset (asynchronous, any time, including mid-read):
  - cpu_state=IDLE, starve_cnt=0, vga_valid=0, vga_gnt=0, ram_we=0, ram_addr=0, avl_waitrequest=1, avl_readdata=0, vga_rdata=0.
  - An in-flight read is dropped; no late valid is produced.
  - Grants are suppressed while Reset_h=1.
- Simultaneous events:
  - A CPU write and a VGA read to the same address in different cycles are ordered by grant order. The RAM is read-old-data; no bypass.
  - vga_req dropped without a grant: no response generated.

Decomposition:
- chess_pkg holds:
  - localparams BOARD_ADDR_W=6 and PIECE_W=4.
  - typedef piece_t (enum: EMPTY, PAWN, KNIGHT, BISHOP, ROOK, QUEEN, KING, with a colour bit).
  - typedef cpu_state_t {IDLE, RD_DATA}.
- One sub-module is natural: starve_counter (saturating counter with clear/inc/at_max). Grant logic and the FSM stay in board_ram_arbiter.

Test Plan:
- VGA only, vga_blank=0: vga_req with addr 0..63 continuously, RAM preloaded with addr[3:0] -> vga_gnt every cycle, vga_valid every cycle from cycle 2, vga_rdata sequence 0,1,...,F,0...
- CPU write in blanking: vga_blank=1, vga_req=1, avl_write addr=12 data=0x9 -> same cycle ram_we=1, ram_addr=12, avl_waitrequest=0, vga_gnt=0. A subsequent VGA read of 12 returns 0x9.
- CPU read: avl_read addr=5 (RAM[5]=0x3), VGA idle -> waitrequest 1 in the grant cycle, 0 in the next cycle with avl_readdata=0x3. Exactly one waitrequest-low cycle.
- Starvation: vga_blank=0, vga_req held high, avl_write pending from cycle 0 -> CPU granted in cycle 15 (STARVE_MAX). vga_gnt=0 only in that cycle; starve_cnt=0 afterward.
- Reset mid-read: assert Reset_h in the RD_DATA cycle -> avl_waitrequest=1, vga_valid=0, ram_we=0 immediately. After release, no stray readdata/valid is produced, and a new read completes normally.
- Write+read simultaneous: avl_read=avl_write=1, addr=7, data=0xE -> treated as a write. RAM[7]=0xE, single waitrequest-low cycle, cpu_state stays IDLE.

Source files
------------

// File: rtl/chess_pkg.sv
// ---------------------------------------------------------------------------
// chess_pkg
// Shared types and sizes for the chess board-state datapath.
//   BOARD_ADDR_W : address width of the 64-square board RAM
//   PIECE_W      : width of one stored piece code (colour bit + piece type)
//   piece_type_t : the six piece kinds plus an empty square
//   piece_t      : packed piece code as it is stored in the board RAM
//   cpu_state_t  : Avalon-side access FSM states of the board RAM arbiter
// ---------------------------------------------------------------------------
package chess_pkg;

    localparam int BOARD_ADDR_W = 6;
    localparam int PIECE_W      = 4;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } piece_type_t;

    // The colour bit sits in the MSB so the renderer can pick a palette
    // from a single bit before decoding the piece shape.
    typedef struct packed {
        logic        colour;
        piece_type_t kind;
    } piece_t;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_DATA = 1'b1
    } cpu_state_t;

endpackage

// File: rtl/starve_counter.sv
// ---------------------------------------------------------------------------
// starve_counter
// Saturating counter that tracks how long a pending CPU request has been
// refused. Clear takes precedence over increment.
//   Clk     : system clock
//   Reset_h : asynchronous active-high reset, clears the count
//   clr     : return the count to zero
//   inc     : count one more refused cycle (holds once MAX is reached)
//   at_max  : count has reached MAX
// ---------------------------------------------------------------------------
import chess_pkg::*;

module starve_counter #(
    parameter int MAX = 15,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic Clk,
    input  logic Reset_h,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [W-1:0] count;

    assign at_max = (count == W'(MAX));

    // The count only moves while the request keeps being refused; it stops
    // at MAX so the force-grant condition stays asserted until it is used.
    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// ---------------------------------------------------------------------------
// board_ram_arbiter
// Shares the single-port board-state RAM (synchronous read, 1-cycle latency)
// between the VGA square renderer and the NIOS II Avalon-MM slave.
// VGA wins during active video, the CPU wins during blanking, and a
// starvation counter force-grants a CPU request refused STARVE_MAX times.
//   Clk, Reset_h                 : clock, asynchronous active-high reset
//   vga_blank                    : blanking interval indicator
//   vga_req/vga_addr             : renderer read request (level, held)
//   vga_gnt/vga_valid/vga_rdata  : accept strobe, data one cycle later
//   avl_read/avl_write/avl_addr/avl_writedata : Avalon slave request
//   avl_readdata/avl_waitrequest : Avalon slave response
//   ram_addr/ram_we/ram_wdata    : RAM command
//   ram_rdata                    : RAM read data (one cycle after address)
// ---------------------------------------------------------------------------
import chess_pkg::*;

module board_ram_arbiter #(
    parameter int ADDR_W     = BOARD_ADDR_W,
    parameter int DATA_W     = PIECE_W,
    parameter int STARVE_MAX = 15
) (
    input  logic              Clk,
    input  logic              Reset_h,
    input  logic              vga_blank,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              avl_read,
    input  logic              avl_write,
    input  logic [ADDR_W-1:0] avl_addr,
    input  logic [DATA_W-1:0] avl_writedata,
    output logic [DATA_W-1:0] avl_readdata,
    output logic              avl_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    cpu_state_t        cpu_state;
    cpu_state_t        next_state;
    logic              cpu_pending;
    logic              cpu_gnt;
    logic              starve_max;
    logic              starve_inc;
    logic [ADDR_W-1:0] last_addr;

    // A request is only pending while the FSM can accept a new access; the
    // second half of a read is never re-arbitrated.
    assign cpu_pending = (avl_read || avl_write) && (cpu_state == IDLE);
    assign starve_inc  = cpu_pending && !cpu_gnt;
    assign ram_wdata   = avl_writedata;
    assign vga_rdata   = vga_valid ? ram_rdata : '0;

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .Clk     (Clk),
        .Reset_h (Reset_h),
        .clr     (!starve_inc),
        .inc     (starve_inc),
        .at_max  (starve_max)
    );

    // CPU access state register. Reset drops any in-flight read so no late
    // Avalon response can appear after reset is released.
    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            cpu_state <= IDLE;
        end else begin
            cpu_state <= next_state;
        end
    end

    // VGA data is valid the cycle after its grant. The last granted address
    // is kept so the RAM address bus stays still when nobody uses it.
    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            vga_valid <= 1'b0;
            last_addr <= '0;
        end else begin
            vga_valid <= vga_gnt;
            if (cpu_gnt || vga_gnt) begin
                last_addr <= ram_addr;
            end
        end
    end

    // Grant decision, RAM mux and CPU FSM next state. A simultaneous read
    // and write is a write, so the read branch only triggers without write.
    // Writes finish in their grant cycle; reads answer in RD_DATA, during
    // which the RAM is free for the renderer.
    always_comb begin
        next_state      = cpu_state;
        cpu_gnt         = 1'b0;
        vga_gnt         = 1'b0;
        ram_we          = 1'b0;
        ram_addr        = last_addr;
        avl_waitrequest = 1'b1;
        avl_readdata    = '0;

        if (!Reset_h) begin
            if (cpu_pending && (!vga_req || vga_blank || starve_max)) begin
                cpu_gnt = 1'b1;
            end else if (vga_req) begin
                vga_gnt = 1'b1;
            end
        end

        if (cpu_gnt) begin
            ram_addr = avl_addr;
            if (avl_write) begin
                ram_we          = 1'b1;
                avl_waitrequest = 1'b0;
            end else begin
                next_state = RD_DATA;
            end
        end else if (vga_gnt) begin
            ram_addr = vga_addr;
        end

        if (cpu_state == RD_DATA) begin
            avl_waitrequest = 1'b0;
            avl_readdata    = ram_rdata;
            next_state      = IDLE;
        end
    end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_board_ram_arbiter
// Directed bench for board_ram_arbiter with a small synchronous-read RAM
// model (read-old-data) attached to the RAM port.
// ---------------------------------------------------------------------------
module tb_board_ram_arbiter;

    logic       Clk;
    logic       Reset_h;
    logic       vga_blank;
    logic       vga_req;
    logic [5:0] vga_addr;
    logic       vga_gnt;
    logic       vga_valid;
    logic [3:0] vga_rdata;
    logic       avl_read;
    logic       avl_write;
    logic [5:0] avl_addr;
    logic [3:0] avl_writedata;
    logic [3:0] avl_readdata;
    logic       avl_waitrequest;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata;

    logic [3:0] mem [64];
    logic       loadRam;
    int         checkCount;
    int         errorCount;

    board_ram_arbiter dut (
        .Clk             (Clk),
        .Reset_h         (Reset_h),
        .vga_blank       (vga_blank),
        .vga_req         (vga_req),
        .vga_addr        (vga_addr),
        .vga_gnt         (vga_gnt),
        .vga_valid       (vga_valid),
        .vga_rdata       (vga_rdata),
        .avl_read        (avl_read),
        .avl_write       (avl_write),
        .avl_addr        (avl_addr),
        .avl_writedata   (avl_writedata),
        .avl_readdata    (avl_readdata),
        .avl_waitrequest (avl_waitrequest),
        .ram_addr        (ram_addr),
        .ram_we          (ram_we),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata)
    );

    // 50 MHz clock
    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    // Board RAM model: preloaded with addr[3:0] while loadRam is set,
    // otherwise a synchronous single-port RAM returning the old data.
    always @(posedge Clk) begin
        if (loadRam) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 4'(i);
            end
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and returns at
    // the falling edge, where outputs are sampled.
    task automatic applyStimulus(input logic rst, input logic blank,
                                 input logic vreq, input logic [5:0] vaddr,
                                 input logic rd, input logic wr,
                                 input logic [5:0] aaddr,
                                 input logic [3:0] wdata);
        @(posedge Clk);
        #1;
        Reset_h       = rst;
        vga_blank     = blank;
        vga_req       = vreq;
        vga_addr      = vaddr;
        avl_read      = rd;
        avl_write     = wr;
        avl_addr      = aaddr;
        avl_writedata = wdata;
        @(negedge Clk);
    endtask

    // Holds a write against continuous active-video VGA traffic; the write
    // must be refused for 15 cycles and forced through in the 16th.
    task automatic runStarve(input logic [5:0] addr, input logic [3:0] data);
        for (int c = 0; c < 16; c++) begin
            applyStimulus(0, 0, 1, 6'(c + 32), 0, 1, addr, data);
            if (c < 15) begin
                checkOutput("starve_vga_gnt", vga_gnt, 1);
                checkOutput("starve_wait", avl_waitrequest, 1);
            end else begin
                checkOutput("starve_force_gnt", vga_gnt, 0);
                checkOutput("starve_force_we", ram_we, 1);
                checkOutput("starve_force_addr", ram_addr, addr);
                checkOutput("starve_force_wait", avl_waitrequest, 0);
            end
        end
    endtask

    initial begin
        checkCount    = 0;
        errorCount    = 0;
        loadRam       = 1'b1;
        Reset_h       = 1'b1;
        vga_blank     = 1'b0;
        vga_req       = 1'b1;
        vga_addr      = 6'd9;
        avl_read      = 1'b0;
        avl_write     = 1'b0;
        avl_addr      = '0;
        avl_writedata = '0;

        // Reset values, with a VGA request that must not be granted
        @(negedge Clk);
        loadRam = 1'b0;
        checkOutput("rst_vga_gnt", vga_gnt, 0);
        checkOutput("rst_vga_valid", vga_valid, 0);
        checkOutput("rst_vga_rdata", vga_rdata, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_addr", ram_addr, 0);
        checkOutput("rst_wait", avl_waitrequest, 1);
        checkOutput("rst_readdata", avl_readdata, 0);

        // VGA sweep over the whole board in active video
        for (int i = 0; i < 64; i++) begin
            applyStimulus(0, 0, 1, 6'(i), 0, 0, 0, 0);
            checkOutput("sweep_gnt", vga_gnt, 1);
            checkOutput("sweep_addr", ram_addr, i);
            checkOutput("sweep_valid", vga_valid, (i > 0) ? 1 : 0);
            if (i > 0) begin
                checkOutput("sweep_rdata", vga_rdata, (i - 1) % 16);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sweep_last_valid", vga_valid, 1);
        checkOutput("sweep_last_rdata", vga_rdata, 4'hF);
        checkOutput("idle_gnt", vga_gnt, 0);
        checkOutput("idle_addr_hold", ram_addr, 63);
        checkOutput("idle_wait", avl_waitrequest, 1);
        checkOutput("idle_we", ram_we, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle_valid", vga_valid, 0);

        // CPU write in blanking beats a VGA request
        applyStimulus(0, 1, 1, 12, 0, 1, 12, 4'h9);
        checkOutput("blank_wr_we", ram_we, 1);
        checkOutput("blank_wr_addr", ram_addr, 12);
        checkOutput("blank_wr_wait", avl_waitrequest, 0);
        checkOutput("blank_wr_vga_gnt", vga_gnt, 0);
        applyStimulus(0, 1, 1, 12, 0, 0, 0, 0);
        checkOutput("blank_rd_gnt", vga_gnt, 1);
        checkOutput("blank_rd_wait", avl_waitrequest, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("blank_rd_valid", vga_valid, 1);
        checkOutput("blank_rd_rdata", vga_rdata, 4'h9);

        // CPU read of square 5 after writing 3 there
        applyStimulus(0, 1, 0, 0, 0, 1, 5, 4'h3);
        checkOutput("pre_wr_wait", avl_waitrequest, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 5, 0);
        checkOutput("rd_grant_wait", avl_waitrequest, 1);
        checkOutput("rd_grant_addr", ram_addr, 5);
        checkOutput("rd_grant_we", ram_we, 0);
        checkOutput("rd_grant_vga_gnt", vga_gnt, 0);
        applyStimulus(0, 0, 1, 9, 1, 0, 5, 0);
        checkOutput("rd_data_wait", avl_waitrequest, 0);
        checkOutput("rd_data_value", avl_readdata, 4'h3);
        checkOutput("rd_data_vga_gnt", vga_gnt, 1);
        checkOutput("rd_data_vga_addr", ram_addr, 9);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_done_wait", avl_waitrequest, 1);
        checkOutput("rd_done_readdata", avl_readdata, 0);
        checkOutput("rd_vga_valid", vga_valid, 1);
        checkOutput("rd_vga_rdata", vga_rdata, 4'h9);

        // Starvation: two back-to-back force grants
        runStarve(20, 4'hA);
        runStarve(21, 4'hB);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset during the data cycle of a read
        applyStimulus(0, 0, 0, 0, 1, 0, 20, 0);
        checkOutput("rstrd_grant_wait", avl_waitrequest, 1);
        @(posedge Clk);
        #1;
        vga_req  = 1'b1;
        vga_addr = 6'd3;
        #1;
        checkOutput("rstrd_data_wait", avl_waitrequest, 0);
        checkOutput("rstrd_data_value", avl_readdata, 4'hA);
        Reset_h = 1'b1;
        #1;
        checkOutput("rstrd_wait", avl_waitrequest, 1);
        checkOutput("rstrd_readdata", avl_readdata, 0);
        checkOutput("rstrd_vga_gnt", vga_gnt, 0);
        checkOutput("rstrd_valid", vga_valid, 0);
        checkOutput("rstrd_we", ram_we, 0);
        @(negedge Clk);
        checkOutput("rstrd_hold_valid", vga_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstrd_rel_valid", vga_valid, 0);
        checkOutput("rstrd_rel_wait", avl_waitrequest, 1);
        checkOutput("rstrd_rel_readdata", avl_readdata, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 21, 0);
        checkOutput("rstrd_new_grant_wait", avl_waitrequest, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 21, 0);
        checkOutput("rstrd_new_data_wait", avl_waitrequest, 0);
        checkOutput("rstrd_new_data_value", avl_readdata, 4'hB);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstrd_new_done_wait", avl_waitrequest, 1);

        // Read and write together act as a write
        applyStimulus(0, 0, 0, 0, 1, 1, 7, 4'hE);
        checkOutput("rw_we", ram_we, 1);
        checkOutput("rw_addr", ram_addr, 7);
        checkOutput("rw_wait", avl_waitrequest, 0);
        applyStimulus(0, 0, 1, 7, 0, 0, 0, 0);
        checkOutput("rw_after_wait", avl_waitrequest, 1);
        checkOutput("rw_after_vga_gnt", vga_gnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rw_vga_valid", vga_valid, 1);
        checkOutput("rw_vga_rdata", vga_rdata, 4'hE);
        checkOutput("rw_idle_wait", avl_waitrequest, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
